// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard: register-number width,
// datapath width and the pending-write saturation limit.
package reg_scoreboard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REGNOBITS    = 5;
  localparam int DBITS        = 32;
  localparam int CNT_BITS_DEF = 2;

  // Largest number of writes a CNT_BITS-wide counter can track.
  function automatic int sat_limit(input int cnt_bits);
    return (1 << cnt_bits) - 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-stage hazard interface: DE/WB/squash requests in, stall and status out.
interface reg_scoreboard_if #(
  parameter int NUM_REGS  = 32,
  parameter int REGNOBITS = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_SQ    = 2
);

  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*REGNOBITS-1:0] src_regno;
  logic                         issue_valid;
  logic                         issue_wr_reg;
  logic [REGNOBITS-1:0]         issue_regno;
  logic                         wb_valid;
  logic [REGNOBITS-1:0]         wb_regno;
  logic [NUM_SQ-1:0]            sq_valid;
  logic [NUM_SQ*REGNOBITS-1:0]  sq_regno;
  logic                         stall;
  logic [NUM_REGS-1:0]          busy_vec;
  logic [31:0]                  stall_cnt;
  logic                         err;

  // Pipeline side: drives the requests and consumes the hazard status.
  modport master (
    output src_valid, src_regno, issue_valid, issue_wr_reg, issue_regno,
    output wb_valid, wb_regno, sq_valid, sq_regno,
    input  stall, busy_vec, stall_cnt, err
  );

  modport slave (
    input  src_valid, src_regno, issue_valid, issue_wr_reg, issue_regno,
    input  wb_valid, wb_regno, sq_valid, sq_regno,
    output stall, busy_vec, stall_cnt, err
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One pending-write counter: a single increment and up to NUM_DEC decrements per
// cycle are summed; a negative result clamps to zero and flags underflow.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_BITS = 2,
  parameter int NUM_DEC  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic [NUM_DEC-1:0]  dec,
  output logic [CNT_BITS-1:0] count,
  output logic                underflow
);

  localparam int MAX_CNT = sat_limit(CNT_BITS);

  int                  ndec;
  int                  sum;
  logic [CNT_BITS-1:0] count_next;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    ndec       = 0;
    sum        = 0;
    count_next = count;
    underflow  = 1'b0;
    for (int k = 0; k < NUM_DEC; k++) begin
      ndec = ndec + int'(dec[k]);
    end
    sum = int'(count) + int'(inc) - ndec;
    if (sum < 0) begin
      count_next = '0;
      underflow  = 1'b1;
    end else if (sum > MAX_CNT) begin
      count_next = CNT_BITS'(MAX_CNT);
    end else begin
      count_next = CNT_BITS'(sum);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every counter updates together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register and
// stalls decode on RAW hazards or when a destination counter is full.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = reg_scoreboard_pkg::NUM_REGS_DEF,
  parameter int REGNOBITS = reg_scoreboard_pkg::REGNOBITS,
  parameter int NUM_SRC   = 2,
  parameter int NUM_SQ    = 2,
  parameter int CNT_BITS  = reg_scoreboard_pkg::CNT_BITS_DEF,
  parameter int WB_BYPASS = 1
) (
  input logic               clk,
  input logic               reset,
  reg_scoreboard_if.slave   bus
);

  localparam logic [CNT_BITS-1:0] SAT = CNT_BITS'(sat_limit(CNT_BITS));
  localparam int                  NUM_DEC = NUM_SQ + 1;

  logic [CNT_BITS-1:0]  cnt [NUM_REGS];
  logic                 uf  [NUM_REGS];
  logic                 accept;
  logic                 stall;
  logic                 src_hazard;
  logic                 dest_full;
  logic                 bypass;
  logic [REGNOBITS-1:0] rn;
  logic                 any_uf;
  logic [NUM_REGS-1:0]  busy;
  logic [31:0]          stall_cnt;
  logic                 err;

  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  // A source only clears early when its last pending write retires this cycle.
  always_comb begin
    src_hazard = 1'b0;
    bypass     = 1'b0;
    rn         = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rn     = bus.src_regno[i*REGNOBITS +: REGNOBITS];
      bypass = (WB_BYPASS != 0) && (cnt[rn] == CNT_BITS'(1)) &&
               bus.wb_valid && (bus.wb_regno == rn);
      if (bus.src_valid[i] && (rn != '0) && (cnt[rn] != '0) && !bypass) begin
        src_hazard = 1'b1;
      end
    end
    dest_full = bus.issue_wr_reg && (bus.issue_regno != '0) &&
                (cnt[bus.issue_regno] == SAT);
    stall     = bus.issue_valid && (src_hazard || dest_full);
  end

  assign accept = bus.issue_valid && bus.issue_wr_reg &&
                  (bus.issue_regno != '0) && !stall;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [NUM_DEC-1:0] dec;
    logic               inc;

    always_comb begin
      dec    = '0;
      dec[0] = bus.wb_valid && (bus.wb_regno == REGNOBITS'(r));
      for (int j = 0; j < NUM_SQ; j++) begin
        dec[j+1] = bus.sq_valid[j] &&
                   (bus.sq_regno[j*REGNOBITS +: REGNOBITS] == REGNOBITS'(r));
      end
    end

    assign inc = accept && (bus.issue_regno == REGNOBITS'(r));

    sb_counter #(
      .CNT_BITS (CNT_BITS),
      .NUM_DEC  (NUM_DEC)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec       (dec),
      .count     (cnt[r]),
      .underflow (uf[r])
    );
  end

  always_comb begin
    busy   = '0;
    any_uf = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt[r] != '0);
      any_uf  = any_uf | uf[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (bus.issue_valid && stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (any_uf) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.busy_vec  = busy;
  assign bus.stall_cnt = stall_cnt;
  assign bus.err       = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with default parameters (32 regs, 2-bit
// counters, WB bypass on); expected values are hand-computed per step.
module tb_reg_scoreboard;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  reg_scoreboard_if #(
    .NUM_REGS  (32),
    .REGNOBITS (5),
    .NUM_SRC   (2),
    .NUM_SQ    (2)
  ) bus ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.src_valid    = '0;
    bus.src_regno    = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_wr_reg = 1'b0;
    bus.issue_regno  = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_regno     = '0;
    bus.sq_valid     = '0;
    bus.sq_regno     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.issue_valid  = 1'b1;
    bus.issue_wr_reg = 1'b1;
    bus.issue_regno  = r;
  endtask

  task automatic wb(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_regno = r;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset overrides a same-cycle issue and a would-be underflowing WB.
    reset = 1'b1;
    idle();
    issue(5'd9);
    wb(5'd9);
    tick();
    tick();
    check("rst_busy", bus.busy_vec, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    check("rst_stall_cnt", bus.stall_cnt, 32'h0);
    reset = 1'b0;
    idle();
    settle();
    check("idle_stall", {31'b0, bus.stall}, 32'h0);

    // Issue x5, then a reader of x5 stalls until WB bypasses it.
    issue(5'd5);
    settle();
    check("x5_issue_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    idle();
    check("x5_busy", bus.busy_vec, 32'h0000_0020);
    bus.issue_valid = 1'b1;
    bus.src_valid   = 2'b01;
    bus.src_regno   = {5'd0, 5'd5};
    settle();
    for (int c = 0; c < 3; c++) begin
      check("x5_raw_stall", {31'b0, bus.stall}, 32'h1);
      tick();
    end
    check("x5_stall_cnt", bus.stall_cnt, 32'd3);
    wb(5'd5);
    settle();
    check("x5_wb_bypass", {31'b0, bus.stall}, 32'h0);
    tick();
    idle();
    check("x5_busy_clear", bus.busy_vec, 32'h0);
    check("x5_stall_cnt_hold", bus.stall_cnt, 32'd3);

    // Saturate x7 at 3 pending writes; a fourth issue stalls.
    issue(5'd7);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("x7_fill_stall", {31'b0, bus.stall}, 32'h0);
      tick();
    end
    check("x7_busy", bus.busy_vec, 32'h0000_0080);
    settle();
    check("x7_sat_stall", {31'b0, bus.stall}, 32'h1);
    tick();
    check("x7_sat_stall2", {31'b0, bus.stall}, 32'h1);
    tick();
    check("x7_stall_cnt", bus.stall_cnt, 32'd5);
    idle();
    wb(5'd7);
    tick();
    idle();
    check("x7_cnt2_busy", bus.busy_vec, 32'h0000_0080);
    // Count 2 with WB on port-1 source: no bypass.
    bus.issue_valid = 1'b1;
    bus.src_valid   = 2'b10;
    bus.src_regno   = {5'd7, 5'd0};
    wb(5'd7);
    settle();
    check("x7_no_bypass", {31'b0, bus.stall}, 32'h1);
    tick();
    check("x7_stall_cnt2", bus.stall_cnt, 32'd6);
    check("x7_cnt1_busy", bus.busy_vec, 32'h0000_0080);
    check("x7_cnt1_bypass", {31'b0, bus.stall}, 32'h0);
    tick();
    idle();
    check("x7_drained", bus.busy_vec, 32'h0);
    check("x7_err", {31'b0, bus.err}, 32'h0);
    check("x7_stall_cnt3", bus.stall_cnt, 32'd6);

    // Issue and WB of x3 in one cycle with count 1 leaves count 1.
    issue(5'd3);
    tick();
    wb(5'd3);
    settle();
    check("x3_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    idle();
    check("x3_busy_kept", bus.busy_vec, 32'h0000_0008);
    wb(5'd3);
    tick();
    idle();
    check("x3_drained", bus.busy_vec, 32'h0);
    check("x3_err", {31'b0, bus.err}, 32'h0);

    // Double squash drains x4 exactly; a further WB underflows.
    issue(5'd4);
    tick();
    tick();
    idle();
    check("x4_busy", bus.busy_vec, 32'h0000_0010);
    bus.sq_valid = 2'b11;
    bus.sq_regno = {5'd4, 5'd4};
    tick();
    idle();
    check("x4_sq_busy", bus.busy_vec, 32'h0);
    check("x4_sq_err", {31'b0, bus.err}, 32'h0);
    wb(5'd4);
    tick();
    idle();
    check("x4_uf_busy", bus.busy_vec, 32'h0);
    check("x4_uf_err", {31'b0, bus.err}, 32'h1);
    tick();
    check("x4_err_sticky", {31'b0, bus.err}, 32'h1);

    // Register 0 never stalls and never becomes busy.
    issue(5'd0);
    bus.src_valid = 2'b11;
    bus.src_regno = {5'd0, 5'd0};
    settle();
    check("x0_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    idle();
    check("x0_busy", bus.busy_vec, 32'h0);

    // Reset with counters pending clears everything without err.
    issue(5'd9);
    tick();
    issue(5'd10);
    tick();
    idle();
    check("x9_x10_busy", bus.busy_vec, 32'h0000_0600);
    bus.issue_valid = 1'b1;
    bus.src_valid   = 2'b01;
    bus.src_regno   = {5'd0, 5'd9};
    bus.src_valid   = 2'b00;
    settle();
    check("x9_unread_src", {31'b0, bus.stall}, 32'h0);
    idle();
    reset = 1'b1;
    wb(5'd9);
    issue(5'd11);
    tick();
    reset = 1'b0;
    idle();
    settle();
    check("rst2_busy", bus.busy_vec, 32'h0);
    check("rst2_err", {31'b0, bus.err}, 32'h0);
    check("rst2_stall_cnt", bus.stall_cnt, 32'h0);
    check("rst2_stall", {31'b0, bus.stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
